// File: rtl/mem_pkg.sv
// Shared types and lane/alignment helpers for the wait-state data memory.
package mem_pkg;

    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0011,
        LHU = 4'b0100
    } load_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dm_state_t;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    function automatic logic misaligned(input logic rd, input logic [3:0] mask,
                                        input logic [1:0] a);
        logic m;
        m = 1'b0;
        if (rd) begin
            case (mask)
                LH, LHU: m = a[0];
                LW:      m = (a != 2'b00);
                default: m = 1'b0;
            endcase
        end else begin
            case (mask)
                BE_B0, BE_B1, BE_B2, BE_B3: m = (mask != (4'b0001 << a));
                BE_H0, BE_H1:               m = a[0];
                BE_W:                       m = (a != 2'b00);
                default:                    m = 1'b0;
            endcase
        end
        return m;
    endfunction

    // Illegal lane patterns write nothing.
    function automatic logic [3:0] store_be(input logic [3:0] mask);
        case (mask)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: return mask;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [3:0] mask, input logic [31:0] wdata);
        case (mask)
            BE_B0, BE_B1, BE_B2, BE_B3: return {4{wdata[7:0]}};
            BE_H0, BE_H1:               return {2{wdata[15:0]}};
            default:                    return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_ext.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_sel,
    input  logic [3:0]  code,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[{byte_sel, 3'b000} +: 8];
        h = byte_sel[1] ? word[31:16] : word[15:0];
        case (code)
            LB:      data = {{24{b[7]}}, b};
            LH:      data = {{16{h[15]}}, h};
            LW:      data = word;
            LBU:     data = {24'd0, b};
            LHU:     data = {16'd0, h};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable data memory with a wait-state sequencer that stalls the core.
//   state | meaning
//   IDLE  | waiting for a request; WAIT_STATES=0 accesses complete here
//   BUSY  | latched request counting down its wait states
//   DONE  | read word presented / write commits on exit edge
module data_mem
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        rd,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES - 1);
    localparam bit         USE_FSM = (WAIT_STATES > 0);

    logic [31:0] mem [DEPTH_WORDS];

    dm_state_t   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic [3:0]  mask_q, mask_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rword_q, rword_d;

    logic [AW-1:0] idx_in, wr_idx;
    logic          req, mis, ok, accept, fast, done, rd_valid;
    logic [3:0]    wr_be, ext_code;
    logic [31:0]   wr_data, ext_word, ext_data;
    logic [1:0]    ext_sel;
    logic          unused_addr;

    assign idx_in      = addr[AW+1:2];
    assign unused_addr = ^addr[31:AW+2];

    assign req      = ~cs && (state_q == IDLE);
    assign mis      = misaligned(rd, mask, addr[1:0]);
    assign ok       = req & ~mis;
    assign accept   = ok & USE_FSM;
    assign fast     = ok & ~USE_FSM;
    assign done     = (state_q == DONE);
    assign stall    = accept | (state_q == BUSY);
    assign misalign = req & mis;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rword_d = rword_q;
        case (state_q)
            IDLE: if (accept) begin
                rd_d    = rd;
                mask_d  = mask;
                idx_d   = idx_in;
                sel_d   = addr[1:0];
                wdata_d = wdata;
                cnt_d   = WS_LOAD;
                // A single wait state is covered by the request cycle itself.
                if (WAIT_STATES == 1) begin
                    state_d = DONE;
                    rword_d = mem[idx_in];
                end else begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = DONE;
                    rword_d = mem[idx_q];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rd_q    <= 1'b0;
            mask_q  <= 4'd0;
            idx_q   <= '0;
            sel_q   <= 2'd0;
            wdata_q <= 32'd0;
            rword_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rword_q <= rword_d;
        end
    end

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = store_lanes(mask, wdata);
        wr_idx  = idx_in;
        if (fast && !rd) begin
            wr_be = store_be(mask);
        end else if (done && !rd_q) begin
            wr_be   = store_be(mask_q);
            wr_data = store_lanes(mask_q, wdata_q);
            wr_idx  = idx_q;
        end
    end

    // Reset suppresses the commit so an aborted access leaves memory intact.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign ext_word = done ? rword_q : mem[idx_in];
    assign ext_sel  = done ? sel_q : addr[1:0];
    assign ext_code = done ? mask_q : mask;
    assign rd_valid = (done & rd_q) | (fast & rd);

    load_ext u_load_ext (
        .word     (ext_word),
        .byte_sel (ext_sel),
        .code     (ext_code),
        .data     (ext_data)
    );

    assign rdata = rd_valid ? ext_data : 32'd0;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: a WAIT_STATES=2 instance driven from a vector table and a WAIT_STATES=0 instance.
module tb_data_mem;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_cs = 1'b1, a_rd = 1'b0;
    logic [3:0]  a_mask = 4'd0;
    logic [31:0] a_addr = 32'd0, a_wdata = 32'd0, a_rdata;
    logic        a_stall, a_mis;

    logic        z_cs = 1'b1, z_rd = 1'b0;
    logic [3:0]  z_mask = 4'd0;
    logic [31:0] z_addr = 32'd0, z_wdata = 32'd0, z_rdata;
    logic        z_stall, z_mis;

    data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dm (
        .clk(clk), .rst_n(rst_n), .cs(a_cs), .rd(a_rd), .mask(a_mask), .addr(a_addr),
        .wdata(a_wdata), .rdata(a_rdata), .stall(a_stall), .misalign(a_mis)
    );

    data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dm0 (
        .clk(clk), .rst_n(rst_n), .cs(z_cs), .rd(z_rd), .mask(z_mask), .addr(z_addr),
        .wdata(z_wdata), .rdata(z_rdata), .stall(z_stall), .misalign(z_mis)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[19];

    // Issues one request on the 2-wait-state instance; returns sampled in its DONE cycle.
    task automatic run_vec(input string tag, input vec_t v);
        int  n;
        bit  fin;
        @(negedge clk);
        a_cs = 1'b0; a_rd = v.rd; a_mask = v.mask; a_addr = v.addr; a_wdata = v.wdata;
        #1;
        if (v.exp_mis) begin
            check({tag, " misalign"}, 32'(a_mis), 32'd1);
            check({tag, " mis stall"}, 32'(a_stall), 32'd0);
            check({tag, " mis rdata"}, a_rdata, 32'd0);
            @(negedge clk);
            a_cs = 1'b1;
            #1;
            check({tag, " mis pulse end"}, 32'(a_mis), 32'd0);
        end else begin
            check({tag, " no misalign"}, 32'(a_mis), 32'd0);
            n = 0;
            fin = 1'b0;
            for (int c = 0; c < 16 && !fin; c++) begin
                if (a_stall) begin
                    n++;
                    @(negedge clk);
                    #1;
                end else begin
                    fin = 1'b1;
                end
            end
            check({tag, " stall cycles"}, 32'(n), 32'd2);
            check({tag, " rdata"}, a_rdata, v.exp_rdata);
        end
    endtask

    task automatic z_step(input string tag, input logic r, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_mis);
        @(negedge clk);
        z_cs = 1'b0; z_rd = r; z_mask = m; z_addr = a; z_wdata = wd;
        #1;
        check({tag, " rdata"}, z_rdata, exp_rd);
        check({tag, " misalign"}, 32'(z_mis), 32'(exp_mis));
        check({tag, " stall"}, 32'(z_stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, BE_W,  32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, LW,    32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, BE_B2, 32'h12,   32'h00000080, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, LB,    32'h12,   32'h0,        32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b1, LBU,   32'h12,   32'h0,        32'h00000080, 1'b0};
        vecs[5]  = '{1'b1, LW,    32'h10,   32'h0,        32'hDE80BEEF, 1'b0};
        vecs[6]  = '{1'b0, BE_H1, 32'h22,   32'h00008001, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b1, LH,    32'h22,   32'h0,        32'hFFFF8001, 1'b0};
        vecs[8]  = '{1'b1, LHU,   32'h22,   32'h0,        32'h00008001, 1'b0};
        vecs[9]  = '{1'b1, LW,    32'h13,   32'h0,        32'h00000000, 1'b1};
        vecs[10] = '{1'b0, BE_H1, 32'h21,   32'h00001234, 32'h00000000, 1'b1};
        vecs[11] = '{1'b1, LHU,   32'h22,   32'h0,        32'h00008001, 1'b0};
        vecs[12] = '{1'b0, BE_B0, 32'h12,   32'hFFFFFF55, 32'h00000000, 1'b1};
        vecs[13] = '{1'b0, BE_B0, 32'h10,   32'hFFFFFF55, 32'h00000000, 1'b0};
        vecs[14] = '{1'b1, LW,    32'h1010, 32'h0,        32'hDE80BE55, 1'b0};
        vecs[15] = '{1'b1, LH,    32'h10,   32'h0,        32'hFFFFBE55, 1'b0};
        vecs[16] = '{1'b1, LB,    32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[17] = '{1'b1, 4'b0101, 32'h10, 32'h0,        32'h00000000, 1'b0};
        vecs[18] = '{1'b1, LH,    32'h11,   32'h0,        32'h00000000, 1'b1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset a_stall", 32'(a_stall), 32'd0);
        check("reset a_mis", 32'(a_mis), 32'd0);
        check("reset a_rdata", a_rdata, 32'd0);
        check("reset z_stall", 32'(z_stall), 32'd0);
        check("reset z_mis", 32'(z_mis), 32'd0);
        check("reset z_rdata", z_rdata, 32'd0);

        for (int k = 0; k < 19; k++) run_vec($sformatf("vec%0d", k), vecs[k]);
        @(negedge clk);
        a_cs = 1'b1;
        #1;
        check("idle rdata", a_rdata, 32'd0);

        // Reset while BUSY aborts the store.
        run_vec("seed", '{1'b0, BE_W, 32'h40, 32'h11111111, 32'h0, 1'b0});
        @(negedge clk);
        a_cs = 1'b0; a_rd = 1'b0; a_mask = BE_W; a_addr = 32'h40; a_wdata = 32'h22222222;
        #1;
        check("abort req stall", 32'(a_stall), 32'd1);
        @(negedge clk);
        #1;
        check("abort busy stall", 32'(a_stall), 32'd1);
        rst_n = 1'b0;
        a_cs = 1'b1;
        @(negedge clk);
        #1;
        check("abort post-reset stall", 32'(a_stall), 32'd0);
        check("abort post-reset rdata", a_rdata, 32'd0);
        rst_n = 1'b1;
        run_vec("abort busy readback", '{1'b1, LW, 32'h40, 32'h0, 32'h11111111, 1'b0});

        // Reset while DONE also suppresses the commit.
        @(negedge clk);
        a_cs = 1'b0; a_rd = 1'b0; a_mask = BE_W; a_addr = 32'h40; a_wdata = 32'h33333333;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("done-cycle stall", 32'(a_stall), 32'd0);
        rst_n = 1'b0;
        a_cs = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("abort done readback", '{1'b1, LW, 32'h40, 32'h0, 32'h11111111, 1'b0});
        @(negedge clk);
        a_cs = 1'b1;

        // Zero-wait-state instance: single-cycle accesses, never stalls.
        z_step("z sw",  1'b0, BE_W,  32'h08, 32'hCAFEF00D, 32'h00000000, 1'b0);
        z_step("z lw",  1'b1, LW,    32'h08, 32'h0,        32'hCAFEF00D, 1'b0);
        z_step("z sb",  1'b0, BE_B3, 32'h0B, 32'h00000077, 32'h00000000, 1'b0);
        z_step("z lbu", 1'b1, LBU,   32'h0B, 32'h0,        32'h00000077, 1'b0);
        z_step("z lw2", 1'b1, LW,    32'h08, 32'h0,        32'h77FEF00D, 1'b0);
        z_step("z lh",  1'b1, LH,    32'h0A, 32'h0,        32'h000077FE, 1'b0);
        z_step("z lw mis", 1'b1, LW, 32'h09, 32'h0,        32'h00000000, 1'b1);
        @(negedge clk);
        z_cs = 1'b1;
        #1;
        check("z idle rdata", z_rdata, 32'd0);
        check("z idle misalign", 32'(z_mis), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
